// File: rtl/udma_adc_rx_packer.sv
// Purpose : buffers the ADC sample stream in a small FIFO, optionally packing two 16-bit samples per 32-bit word.
// Latency : a word becomes visible on data_rx_valid_o one cycle after the sample/flush cycle that produces it.
// Backpres: data_rx_ready_i stalls the FIFO head; the sample source cannot stall, so pushes into a full FIFO are dropped and counted.
//
// Ports:
//   sys_clk_i, rst_ni                         clock, async active-low reset
//   smp_valid_i, smp_data_i                   single-cycle sample strobe and data
//   cfg_pack_en_i, cfg_flush_i, cfg_clr_i     pack mode, flush pending half, synchronous clear
//   data_rx_o, data_rx_valid_o, data_rx_ready_i, data_rx_datasize_o   uDMA RX handshake
//   fifo_level_o, overflow_o, drop_cnt_o      status
module udma_adc_rx_packer #(
  parameter int ADC_DATA_WIDTH = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                          sys_clk_i,
  input  logic                          rst_ni,
  input  logic                          smp_valid_i,
  input  logic [ADC_DATA_WIDTH-1:0]     smp_data_i,
  input  logic                          cfg_pack_en_i,
  input  logic                          cfg_flush_i,
  input  logic                          cfg_clr_i,
  output logic [31:0]                   data_rx_o,
  output logic                          data_rx_valid_o,
  input  logic                          data_rx_ready_i,
  output logic [1:0]                    data_rx_datasize_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  output logic [CNT_WIDTH-1:0]          drop_cnt_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {EMPTY_HALF, HAVE_HALF} state_e;

  state_e               state_q, state_d;
  logic [15:0]          pend_q, pend_d;
  logic                 skid_vld_q, skid_vld_d;
  logic [31:0]          skid_dat_q, skid_dat_d;
  logic [LW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          mem_q [FIFO_DEPTH];
  logic [31:0]          mem_d [FIFO_DEPTH];

  logic [31:0] smp_ext;
  logic        empty, full, pop;
  logic        cand0_vld, cand1_vld;
  logic [31:0] cand0_dat, cand1_dat;
  logic        push_vld, wr_en, drop;
  logic [31:0] push_dat;

  assign smp_ext = 32'(smp_data_i);

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = !empty && data_rx_ready_i;

  assign data_rx_valid_o    = !empty;
  assign data_rx_o          = empty ? 32'h0 : mem_q[rptr_q[AW-1:0]];
  assign data_rx_datasize_o = 2'b10;
  assign fifo_level_o       = wptr_q - rptr_q;
  assign overflow_o         = ovf_q;
  assign drop_cnt_o         = cnt_q;

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    cand0_vld  = 1'b0;
    cand0_dat  = 32'h0;
    cand1_vld  = 1'b0;
    cand1_dat  = 32'h0;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    push_vld   = 1'b0;
    push_dat   = 32'h0;
    wr_en      = 1'b0;
    drop       = 1'b0;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    ovf_d      = ovf_q;
    cnt_d      = cnt_q;
    mem_d      = mem_q;

    // Words produced this cycle, in FIFO order.
    if (state_q == HAVE_HALF && !cfg_pack_en_i) begin
      // Leaving pack mode with a half pending: pad it out, the sample follows.
      cand0_vld = 1'b1;
      cand0_dat = {16'h0, pend_q};
      state_d   = EMPTY_HALF;
      if (smp_valid_i) begin
        cand1_vld = 1'b1;
        cand1_dat = smp_ext;
      end
    end else if (!cfg_pack_en_i) begin
      if (smp_valid_i) begin
        cand0_vld = 1'b1;
        cand0_dat = smp_ext;
      end
    end else if (state_q == EMPTY_HALF) begin
      if (smp_valid_i) begin
        pend_d  = smp_ext[15:0];
        state_d = HAVE_HALF;
      end
    end else begin
      // A sample completing the pair takes precedence over a flush.
      if (smp_valid_i) begin
        cand0_vld = 1'b1;
        cand0_dat = {smp_ext[15:0], pend_q};
        state_d   = EMPTY_HALF;
      end else if (cfg_flush_i) begin
        cand0_vld = 1'b1;
        cand0_dat = {16'h0, pend_q};
        state_d   = EMPTY_HALF;
      end
    end

    // One FIFO write per cycle: an older skid word goes first, any leftover
    // is parked in the skid. A full skid is always followed by an EMPTY_HALF
    // cycle that yields at most one word, so nothing is ever left over twice.
    if (skid_vld_q) begin
      push_vld   = 1'b1;
      push_dat   = skid_dat_q;
      skid_vld_d = cand0_vld;
      skid_dat_d = cand0_dat;
    end else begin
      push_vld   = cand0_vld;
      push_dat   = cand0_dat;
      skid_vld_d = cand1_vld;
      skid_dat_d = cand1_dat;
    end

    wr_en = push_vld && (!full || pop);
    drop  = push_vld && full && !pop;

    if (wr_en) mem_d[wptr_q[AW-1:0]] = push_dat;
    wptr_d = wptr_q + LW'(wr_en);
    rptr_d = rptr_q + LW'(pop);
    if (drop) begin
      ovf_d = 1'b1;
      if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + 1'b1;
    end

    if (cfg_clr_i) begin
      state_d    = EMPTY_HALF;
      pend_d     = 16'h0;
      skid_vld_d = 1'b0;
      skid_dat_d = 32'h0;
      wptr_d     = '0;
      rptr_d     = '0;
      ovf_d      = 1'b0;
      cnt_d      = '0;
      mem_d      = mem_q;
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= EMPTY_HALF;
      pend_q     <= 16'h0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= 32'h0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 32'h0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ovf_q      <= ovf_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
    end
  end

endmodule

// File: tb/tb_udma_adc_rx_packer.sv
module tb_udma_adc_rx_packer;

  localparam int DEPTH = 4;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        smp_valid;
  logic [15:0] smp_data;
  logic        pack_en, flush, clr, ready;
  logic [31:0] data_rx;
  logic        data_rx_valid;
  logic [1:0]  datasize;
  logic [2:0]  level;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  udma_adc_rx_packer #(.ADC_DATA_WIDTH(16), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(8)) dut (
    .sys_clk_i          (sys_clk),
    .rst_ni             (rst_n),
    .smp_valid_i        (smp_valid),
    .smp_data_i         (smp_data),
    .cfg_pack_en_i      (pack_en),
    .cfg_flush_i        (flush),
    .cfg_clr_i          (clr),
    .data_rx_o          (data_rx),
    .data_rx_valid_o    (data_rx_valid),
    .data_rx_ready_i    (ready),
    .data_rx_datasize_o (datasize),
    .fifo_level_o       (level),
    .overflow_o         (overflow),
    .drop_cnt_o         (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        sv;
    logic [15:0] sd;
    logic        pk, fl, cl, rd;
    logic        ev;
    logic [31:0] ed;
    int          el;
    logic        eo;
    int          ec;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic sv, input logic [15:0] sd, input logic pk, input logic fl,
                     input logic cl, input logic rd, input logic ev, input logic [31:0] ed,
                     input int el, input logic eo, input int ec);
    vec_t v;
    v.sv = sv; v.sd = sd; v.pk = pk; v.fl = fl; v.cl = cl; v.rd = rd;
    v.ev = ev; v.ed = ed; v.el = el; v.eo = eo; v.ec = ec;
    vt.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] ed,
                         input int el, input logic eo, input int ec);
    chk({tag, ".valid"},    32'(data_rx_valid), 32'(ev));
    chk({tag, ".data"},     data_rx,            ed);
    chk({tag, ".level"},    32'(level),         32'(el));
    chk({tag, ".overflow"}, 32'(overflow),      32'(eo));
    chk({tag, ".drop_cnt"}, 32'(drop_cnt),      32'(ec));
    chk({tag, ".datasize"}, 32'(datasize),      32'd2);
  endtask

  task automatic drive(input logic sv, input logic [15:0] sd, input logic pk,
                       input logic fl, input logic cl, input logic rd);
    smp_valid = sv; smp_data = sd; pack_en = pk; flush = fl; clr = cl; ready = rd;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Reference model: FIFO as a queue of words, pack state as "have a half".
  logic [31:0] mq[$];
  logic [31:0] m_defer[$];
  bit          m_have;
  logic [15:0] m_pend;
  bit          m_ovf;
  int          m_cnt;

  task automatic model_reset();
    mq.delete(); m_defer.delete(); m_have = 0; m_pend = 16'h0; m_ovf = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic sv, input logic [15:0] sd, input logic pk,
                            input logic fl, input logic cl, input logic rd);
    logic [31:0] w[$];
    logic [31:0] tmp;
    bit pop, full;
    pop  = (mq.size() > 0) && rd;
    full = (mq.size() == DEPTH);
    if (cl) begin
      model_reset();
      return;
    end
    w = m_defer;
    m_defer.delete();
    if (m_have && !pk) begin
      w.push_back({16'h0, m_pend}); m_have = 0;
      if (sv) w.push_back({16'h0, sd});
    end else if (!pk) begin
      if (sv) w.push_back({16'h0, sd});
    end else if (!m_have) begin
      if (sv) begin m_pend = sd; m_have = 1; end
    end else if (sv) begin
      w.push_back({sd, m_pend}); m_have = 0;
    end else if (fl) begin
      w.push_back({16'h0, m_pend}); m_have = 0;
    end
    if (pop) tmp = mq.pop_front();
    if (w.size() > 0) begin
      if (!full || pop) mq.push_back(w[0]);
      else begin
        m_ovf = 1;
        if (m_cnt < 255) m_cnt++;
      end
      for (int i = 1; i < w.size(); i++) m_defer.push_back(w[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 16'h0, 0, 0, 0, 0);
    repeat (2) @(posedge sys_clk);
    #1;
    chk_all("reset", 0, 32'h0, 0, 0, 0);
    rst_n = 1'b1;

    //   sv sd       pk fl cl rd   ev ed            el eo ec
    add(1, 16'h1234, 0, 0, 0, 1,   1, 32'h00001234, 1, 0, 0);
    add(0, 16'h0,    0, 0, 0, 1,   0, 32'h0,        0, 0, 0);
    add(0, 16'h0,    0, 0, 0, 1,   0, 32'h0,        0, 0, 0);
    add(1, 16'h5678, 0, 0, 0, 1,   1, 32'h00005678, 1, 0, 0);
    add(0, 16'h0,    0, 0, 0, 1,   0, 32'h0,        0, 0, 0);
    add(1, 16'hAAAA, 1, 0, 0, 0,   0, 32'h0,        0, 0, 0);
    add(1, 16'hBBBB, 1, 0, 0, 0,   1, 32'hBBBBAAAA, 1, 0, 0);
    add(1, 16'hCCCC, 1, 0, 0, 0,   1, 32'hBBBBAAAA, 1, 0, 0);
    add(0, 16'h0,    1, 1, 0, 0,   1, 32'hBBBBAAAA, 2, 0, 0);
    add(0, 16'h0,    1, 0, 0, 1,   1, 32'h0000CCCC, 1, 0, 0);
    add(0, 16'h0,    1, 0, 0, 1,   0, 32'h0,        0, 0, 0);
    add(0, 16'h0,    1, 1, 0, 1,   0, 32'h0,        0, 0, 0);
    add(1, 16'h1111, 1, 0, 0, 0,   0, 32'h0,        0, 0, 0);
    add(1, 16'h2222, 0, 0, 0, 0,   1, 32'h00001111, 1, 0, 0);
    add(0, 16'h0,    0, 0, 0, 0,   1, 32'h00001111, 2, 0, 0);
    add(0, 16'h0,    0, 0, 0, 1,   1, 32'h00002222, 1, 0, 0);
    add(0, 16'h0,    0, 0, 0, 1,   0, 32'h0,        0, 0, 0);
    add(1, 16'h0001, 0, 0, 0, 0,   1, 32'h00000001, 1, 0, 0);
    add(1, 16'h0002, 0, 0, 0, 0,   1, 32'h00000001, 2, 0, 0);
    add(1, 16'h0003, 0, 0, 0, 0,   1, 32'h00000001, 3, 0, 0);
    add(1, 16'h0004, 0, 0, 0, 0,   1, 32'h00000001, 4, 0, 0);
    add(1, 16'h0005, 0, 0, 0, 0,   1, 32'h00000001, 4, 1, 1);
    add(1, 16'h0006, 0, 0, 0, 0,   1, 32'h00000001, 4, 1, 2);
    add(1, 16'h0007, 0, 0, 0, 1,   1, 32'h00000002, 4, 1, 2);
    add(0, 16'h0,    0, 0, 0, 1,   1, 32'h00000003, 3, 1, 2);
    add(0, 16'h0,    0, 0, 0, 1,   1, 32'h00000004, 2, 1, 2);
    add(0, 16'h0,    0, 0, 0, 1,   1, 32'h00000007, 1, 1, 2);
    add(0, 16'h0,    0, 0, 0, 1,   0, 32'h0,        0, 1, 2);
    add(1, 16'h0008, 0, 0, 0, 0,   1, 32'h00000008, 1, 1, 2);
    add(1, 16'h0009, 0, 0, 0, 0,   1, 32'h00000008, 2, 1, 2);
    add(1, 16'h000A, 0, 0, 0, 0,   1, 32'h00000008, 3, 1, 2);
    add(1, 16'h000B, 0, 0, 1, 1,   0, 32'h0,        0, 0, 0);
    add(0, 16'h0,    0, 0, 0, 0,   0, 32'h0,        0, 0, 0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].sv, vt[i].sd, vt[i].pk, vt[i].fl, vt[i].cl, vt[i].rd);
      tick();
      chk_all($sformatf("row%0d", i), vt[i].ev, vt[i].ed, vt[i].el, vt[i].eo, vt[i].ec);
    end

    // Drop counter saturates: 4 stored, 256 dropped.
    for (int i = 0; i < 260; i++) begin
      drive(1, 16'(i + 16'h40), 0, 0, 0, 0);
      tick();
    end
    drive(0, 16'h0, 0, 0, 0, 0);
    chk_all("saturate", 1, 32'h00000040, 4, 1, 255);

    // Asynchronous reset mid-burst takes effect without a clock edge.
    drive(1, 16'h7777, 0, 0, 0, 1);
    #3 rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 32'h0, 0, 0, 0);
    tick();
    drive(0, 16'h0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk_all("post_rst", 0, 32'h0, 0, 0, 0);

    // Packed overflow: the fifth pair is dropped whole and counts once.
    for (int i = 0; i < 10; i++) begin
      drive(1, 16'(16'h100 + i), 1, 0, 0, 0);
      tick();
    end
    drive(0, 16'h0, 1, 0, 0, 0);
    chk_all("pack_drop", 1, 32'h01010100, 4, 1, 1);
    drive(0, 16'h0, 0, 0, 1, 0);
    tick();
    chk_all("pack_drop_clr", 0, 32'h0, 0, 0, 0);

    // Randomized run against the reference model.
    drive(0, 16'h0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    begin
      logic pk;
      pk = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        logic sv, fl, cl, rd;
        logic [15:0] sd;
        if ($urandom_range(0, 15) == 0) pk = ~pk;
        sv = ($urandom_range(0, 9) < 5);
        sd = 16'($urandom);
        fl = ($urandom_range(0, 9) == 0);
        cl = ($urandom_range(0, 63) == 0);
        rd = ($urandom_range(0, 9) < 4);
        drive(sv, sd, pk, fl, cl, rd);
        chk_all($sformatf("rnd%0d", c), mq.size() > 0, (mq.size() > 0) ? mq[0] : 32'h0,
                mq.size(), m_ovf, m_cnt);
        model_step(sv, sd, pk, fl, cl, rd);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
